// File: rtl/controle_exibicao_pkg.sv
// Shared constants for the LED replay sequencer: state encoding, default widths and timings.
package controle_exibicao_pkg;

  localparam int unsigned ADDR_W_PADRAO = 4;
  localparam int unsigned DATA_W_PADRAO = 4;
  localparam int unsigned T_ON_PADRAO   = 500;
  localparam int unsigned T_OFF_PADRAO  = 250;

  localparam int unsigned ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] OCIOSO  = 3'd0;
  localparam logic [ESTADO_W-1:0] LE_MEM  = 3'd1;
  localparam logic [ESTADO_W-1:0] ACENDE  = 3'd2;
  localparam logic [ESTADO_W-1:0] APAGA   = 3'd3;
  localparam logic [ESTADO_W-1:0] PROXIMO = 3'd4;
  localparam logic [ESTADO_W-1:0] FIM     = 3'd5;
  localparam logic [ESTADO_W-1:0] INTRO   = 3'd6;

  function automatic int unsigned maximo(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controle_exibicao_temporizador.sv
// Interval counter for the on/off LED phases: clears to zero, counts while enabled,
// and stops at the terminal value so it can never wrap.
module temporizador_exibicao #(
  parameter int unsigned W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_limpa,
  input  logic         i_habilita,
  input  logic [W-1:0] i_alvo,
  output logic         o_fim
);

  logic [W-1:0] r_cont;

  assign o_fim = (r_cont == i_alvo);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cont <= '0;
    end else if (i_limpa) begin
      r_cont <= '0;
    end else if (i_habilita && !o_fim) begin
      r_cont <= r_cont + W'(1);
    end
  end

endmodule

// File: rtl/controle_exibicao.sv
// Replays the stored move sequence (addresses 0..limite) on the LEDs with fixed on/off timing.
// Optional all-LEDs intro flash before the first move: define CONTROLE_EXIBICAO_INTRO_EN.
module controle_exibicao
  import controle_exibicao_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_PADRAO,
  parameter int unsigned DATA_W = DATA_W_PADRAO,
  parameter int unsigned T_ON   = T_ON_PADRAO,
  parameter int unsigned T_OFF  = T_OFF_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto
);

  localparam int unsigned TW = $clog2(maximo(T_ON, T_OFF) + 1);
  localparam logic [TW-1:0] ALVO_ON  = TW'(T_ON - 1);
  localparam logic [TW-1:0] ALVO_OFF = TW'(T_OFF - 1);

  logic [ESTADO_W-1:0] r_estado;
  logic [ESTADO_W-1:0] w_prox;
  logic [ADDR_W-1:0]   r_endereco;
  logic [ADDR_W-1:0]   r_limite;
  logic [DATA_W-1:0]   r_leds;
  logic                r_ocupado;
  logic                r_pronto;
  logic                w_tmr_limpa;
  logic                w_tmr_habilita;
  logic                w_tmr_fim;
  logic [TW-1:0]       w_tmr_alvo;
`ifdef CONTROLE_EXIBICAO_INTRO_EN
  logic                r_intro_apaga;
  logic                w_intro_apaga_prox;
`endif

  assign endereco = r_endereco;
  assign leds     = r_leds;
  assign ocupado  = r_ocupado;
  assign pronto   = r_pronto;

  temporizador_exibicao #(
    .W(TW)
  ) u_temporizador (
    .i_clock    (clock),
    .i_reset_n  (reset),
    .i_limpa    (w_tmr_limpa),
    .i_habilita (w_tmr_habilita),
    .i_alvo     (w_tmr_alvo),
    .o_fim      (w_tmr_fim)
  );

  always_comb begin
    w_prox         = r_estado;
    w_tmr_habilita = 1'b0;
    w_tmr_alvo     = ALVO_OFF;
`ifdef CONTROLE_EXIBICAO_INTRO_EN
    w_intro_apaga_prox = r_intro_apaga;
`endif
    case (r_estado)
      OCIOSO: begin
        if (iniciar) begin
`ifdef CONTROLE_EXIBICAO_INTRO_EN
          w_prox = INTRO;
`else
          w_prox = LE_MEM;
`endif
        end
      end
      LE_MEM:  w_prox = ACENDE;
      ACENDE: begin
        w_tmr_habilita = 1'b1;
        w_tmr_alvo     = ALVO_ON;
        if (w_tmr_fim) w_prox = APAGA;
      end
      APAGA: begin
        w_tmr_habilita = 1'b1;
        if (w_tmr_fim) w_prox = PROXIMO;
      end
      PROXIMO: w_prox = (r_endereco == r_limite) ? FIM : LE_MEM;
      FIM:     w_prox = OCIOSO;
`ifdef CONTROLE_EXIBICAO_INTRO_EN
      // INTRO is one state with a lit phase then a blank phase, tracked by r_intro_apaga
      INTRO: begin
        w_tmr_habilita = 1'b1;
        if (!r_intro_apaga) begin
          w_tmr_alvo = ALVO_ON;
          if (w_tmr_fim) w_intro_apaga_prox = 1'b1;
        end else if (w_tmr_fim) begin
          w_prox             = LE_MEM;
          w_intro_apaga_prox = 1'b0;
        end
      end
`endif
      default: w_prox = OCIOSO;
    endcase

    if (abortar) begin
      w_prox = OCIOSO;
`ifdef CONTROLE_EXIBICAO_INTRO_EN
      w_intro_apaga_prox = 1'b0;
`endif
    end

    w_tmr_limpa = (w_prox != r_estado);
`ifdef CONTROLE_EXIBICAO_INTRO_EN
    if (w_intro_apaga_prox != r_intro_apaga) w_tmr_limpa = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_endereco <= '0;
      r_limite   <= '0;
      r_leds     <= '0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
`ifdef CONTROLE_EXIBICAO_INTRO_EN
      r_intro_apaga <= 1'b0;
`endif
    end else begin
      r_estado  <= w_prox;
      r_ocupado <= (w_prox != OCIOSO);
      r_pronto  <= (w_prox == FIM);
`ifdef CONTROLE_EXIBICAO_INTRO_EN
      r_intro_apaga <= w_intro_apaga_prox;
`endif
      if (abortar) begin
        r_leds <= '0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (iniciar) begin
              r_limite   <= limite;
              r_endereco <= '0;
`ifdef CONTROLE_EXIBICAO_INTRO_EN
              r_leds     <= '1;
`endif
            end
          end
          LE_MEM:  r_leds <= dado_mem;
          ACENDE:  if (w_tmr_fim) r_leds <= '0;
          PROXIMO: if (r_endereco != r_limite) r_endereco <= r_endereco + ADDR_W'(1);
`ifdef CONTROLE_EXIBICAO_INTRO_EN
          INTRO:   if (w_tmr_fim && !r_intro_apaga) r_leds <= '0;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controle_exibicao.sv
// Self-checking bench for controle_exibicao with T_ON=4, T_OFF=2 against a timeline model.
module tb_controle_exibicao;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int P     = T_ON + T_OFF + 2;
`ifdef CONTROLE_EXIBICAO_INTRO_EN
  localparam int INTRO_C = T_ON + T_OFF;
`else
  localparam int INTRO_C = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       abortar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;

  logic [3:0] mem [16];
  int checks = 0;
  int errors = 0;

  assign dado_mem = mem[endereco];
  wire [9:0] w_obs = {ocupado, pronto, endereco, leds};

  always #5 clock = ~clock;

  controle_exibicao #(
    .ADDR_W(4),
    .DATA_W(4),
    .T_ON  (T_ON),
    .T_OFF (T_OFF)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .abortar  (abortar),
    .limite   (limite),
    .dado_mem (dado_mem),
    .endereco (endereco),
    .leds     (leds),
    .ocupado  (ocupado),
    .pronto   (pronto)
  );

  // Expected {ocupado, pronto, endereco, leds} n edges after the edge that sampled iniciar.
  function automatic logic [9:0] esperado(input int n, input int lim);
    int k, total, j, r;
    logic [3:0] lv;
    if (n < INTRO_C) return {1'b1, 1'b0, 4'd0, (n < T_ON) ? 4'hF : 4'h0};
    k     = n - INTRO_C;
    total = (lim + 1) * P;
    if (k < total) begin
      j  = k / P;
      r  = k % P;
      lv = (r >= 1 && r <= T_ON) ? mem[j] : 4'h0;
      return {1'b1, 1'b0, 4'(j), lv};
    end
    if (k == total) return {1'b1, 1'b1, 4'(lim), 4'h0};
    return {1'b0, 1'b0, 4'(lim), 4'h0};
  endfunction

  task automatic carrega_padrao();
    for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    carrega_padrao();
    repeat (3) @(posedge clock);
    @(negedge clock);
    exp = '0;
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL reset_held obtido=%b esperado=%b", w_obs, exp);
    end
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL reset_idle n=%0d obtido=%b esperado=%b", n, w_obs, exp);
      end
    end
  endtask

  task automatic test_sequencia(input int lim);
    logic [9:0] exp;
    carrega_padrao();
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'(lim);
    @(posedge clock);
    for (int n = 0; n < (lim + 1) * P + INTRO_C + 4; n++) begin
      @(negedge clock);
      iniciar = 1'b0;
      exp = esperado(n, lim);
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL sequencia lim=%0d n=%0d obtido=%b esperado=%b", lim, n, w_obs, exp);
      end
    end
  endtask

  task automatic test_ignora_iniciar();
    logic [9:0] exp;
    carrega_padrao();
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'd2;
    @(posedge clock);
    for (int n = 0; n < 3 * P + INTRO_C + 4; n++) begin
      @(negedge clock);
      exp = esperado(n, 2);
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL ignora_iniciar n=%0d obtido=%b esperado=%b", n, w_obs, exp);
      end
      iniciar = (n >= INTRO_C + 10 && n <= INTRO_C + 12);
      limite  = (n >= INTRO_C + 10) ? 4'd3 : 4'd2;
    end
    limite = 4'd0;
  endtask

  task automatic test_abortar();
    logic [9:0] exp;
    int ab;
    carrega_padrao();
    ab = INTRO_C + P + 1;
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'd2;
    @(posedge clock);
    for (int n = 0; n < 3 * P + INTRO_C + 4; n++) begin
      @(negedge clock);
      iniciar = 1'b0;
      abortar = (n == ab);
      if (n <= ab) begin
        exp = esperado(n, 2);
        checks++;
        if (w_obs !== exp) begin
          errors++;
          $display("FAIL abortar_pre n=%0d obtido=%b esperado=%b", n, w_obs, exp);
        end
      end else begin
        checks++;
        if ({ocupado, pronto, leds} !== 6'b0) begin
          errors++;
          $display("FAIL abortar_pos n=%0d obtido=%b esperado=%b", n, {ocupado, pronto, leds}, 6'b0);
        end
      end
    end
    abortar = 1'b0;
    @(negedge clock);
    iniciar = 1'b1;
    @(posedge clock);
    for (int n = 0; n < 3 * P + INTRO_C + 3; n++) begin
      @(negedge clock);
      iniciar = 1'b0;
      exp = esperado(n, 2);
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL abortar_reinicio n=%0d obtido=%b esperado=%b", n, w_obs, exp);
      end
    end
  endtask

  task automatic test_reset_meio();
    logic [9:0] exp;
    carrega_padrao();
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'd2;
    @(posedge clock);
    for (int n = 0; n <= INTRO_C + T_ON + 1; n++) begin
      @(negedge clock);
      iniciar = 1'b0;
      exp = esperado(n, 2);
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL reset_meio_pre n=%0d obtido=%b esperado=%b", n, w_obs, exp);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (w_obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_meio_imediato obtido=%b esperado=%b", w_obs, 10'b0);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      checks++;
      if (w_obs !== 10'b0) begin
        errors++;
        $display("FAIL reset_meio_pos n=%0d obtido=%b esperado=%b", n, w_obs, 10'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    int rs;
    carrega_padrao();
    rs = P + INTRO_C + 2;
    @(negedge clock);
    iniciar = 1'b1;
    limite  = 4'd0;
    @(posedge clock);
    for (int n = 0; n < rs + P + INTRO_C + 3; n++) begin
      @(negedge clock);
      if (n >= rs) iniciar = 1'b0;
      exp = (n < rs) ? esperado(n, 0) : esperado(n - rs, 0);
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL back_to_back n=%0d obtido=%b esperado=%b", n, w_obs, exp);
      end
    end
  endtask

  task automatic test_aleatorio();
    logic [9:0] exp;
    int lim;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      lim = (it == 0) ? 15 : int'($urandom_range(0, 15));
      @(negedge clock);
      iniciar = 1'b1;
      limite  = 4'(lim);
      @(posedge clock);
      for (int n = 0; n < (lim + 1) * P + INTRO_C + 3; n++) begin
        @(negedge clock);
        exp = esperado(n, lim);
        checks++;
        if (w_obs !== exp) begin
          errors++;
          $display("FAIL aleatorio lim=%0d n=%0d obtido=%b esperado=%b", lim, n, w_obs, exp);
        end
        limite  = 4'($urandom);
        iniciar = (n <= (lim + 1) * P + INTRO_C) ? 1'($urandom) : 1'b0;
      end
      iniciar = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sequencia(2);
    test_sequencia(0);
    test_ignora_iniciar();
    test_abortar();
    test_reset_meio();
    test_back_to_back();
    test_aleatorio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
